// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the fabric FIFO: read-mode selectors, the prefetch
// state encoding used in first-word-fall-through mode, and a constant-capable
// ceiling-log2 helper used for parameter sanity checks.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 32'sd0;
    localparam int FIFO_MODE_FWFT = 32'sd1;

    // Prefetch stage state: nothing held, RAM read in flight, head word on dout.
    typedef enum logic [1:0] {
        FWFT_EMPTY   = 2'd0,
        FWFT_PRIMING = 2'd1,
        FWFT_VALID   = 2'd2
    } fwft_state_e;

    // Smallest n with 2**n >= value; usable in elaboration-time expressions.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 32'sd0;
        remaining = value - 32'sd1;
        while (remaining > 32'sd0) begin
            result    = result + 32'sd1;
            remaining = remaining >>> 32'd1;
        end
        return result;
    endfunction

endpackage : fifo_pkg

// File: rtl/sdp_ram.sv
// -----------------------------------------------------------------------------
// sdp_ram
// Simple dual-port RAM: one write port, one read port with a registered read
// data output. Storage is left uninitialised and never cleared so the array
// can map onto block or distributed RAM; only the read register is reset.
//
// Ports
//   clk      in   clock
//   rst      in   synchronous active-high reset (read register only)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; loads rd_data from rd_addr on the clock edge
//   rd_addr  in   read address
//   rd_data  out  registered read data, holds when rd_en is low
// -----------------------------------------------------------------------------
module sdp_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 32'sd1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Write port: storage array, deliberately without reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered output, cleared by reset so dout starts at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule : sdp_ram

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO in fabric logic with arbitrary width, power-of-two depth,
// standard or first-word-fall-through read mode and a live occupancy count.
// Capacity is exactly DEPTH words in both modes; in FWFT mode the word parked
// on dout is part of that count.
//
// Ports
//   clk          in   clock
//   rst          in   synchronous active-high reset, wins over wr_en/rd_en
//   wr_en        in   write request, accepted when not full
//   din          in   write data
//   full         out  no space left, writes are dropped
//   almostfull   out  count >= ALMOST_FULL
//   overflow     out  one-cycle pulse after a write attempted while full
//   rd_en        in   read request, accepted when not empty
//   dout         out  read data (registered)
//   empty        out  no readable word
//   almostempty  out  count <= ALMOST_EMPTY
//   underflow    out  one-cycle pulse after a read attempted while empty
//   count        out  words accepted and not yet read
// -----------------------------------------------------------------------------
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 9,
    parameter int FWFT         = FIFO_MODE_FWFT,
    parameter int ALMOST_FULL  = (32'sd1 << ADDR_WIDTH) - 32'sd16,
    parameter int ALMOST_EMPTY = 32'sd16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  almostfull,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  almostempty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int DEPTH = 32'sd1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 32'sd1;

    localparam logic [CW-1:0]         CNT_ZERO_C = CW'(32'd0);
    localparam logic [CW-1:0]         CNT_ONE_C  = CW'(32'd1);
    localparam logic [CW-1:0]         DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0]         AF_C       = CW'(ALMOST_FULL);
    localparam logic [CW-1:0]         AE_C       = CW'(ALMOST_EMPTY);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C  = ADDR_WIDTH'(32'd1);

    // ---------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ---------------------------------------------------------------------
    if (DATA_WIDTH < 32'sd1 || DATA_WIDTH > 32'sd1024) begin : g_bad_data_width
        $error("sync_fifo_param: DATA_WIDTH must be 1..1024");
    end
    if (ADDR_WIDTH < 32'sd1 || ADDR_WIDTH > 32'sd14) begin : g_bad_addr_width
        $error("sync_fifo_param: ADDR_WIDTH must give a depth of 2..16384");
    end
    if (clog2(DEPTH) != ADDR_WIDTH) begin : g_bad_depth
        $error("sync_fifo_param: derived depth is inconsistent with ADDR_WIDTH");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
        $error("sync_fifo_param: FWFT must be 0 or 1");
    end
    if (ALMOST_FULL < 32'sd1 || ALMOST_FULL > DEPTH) begin : g_bad_almost_full
        $error("sync_fifo_param: ALMOST_FULL must be 1..DEPTH");
    end
    if (ALMOST_EMPTY < 32'sd0 || ALMOST_EMPTY > DEPTH - 32'sd1) begin : g_bad_almost_empty
        $error("sync_fifo_param: ALMOST_EMPTY must be 0..DEPTH-1");
    end

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_almostfull;
    logic                  r_almostempty;
    logic                  r_empty;
    logic                  r_overflow;
    logic                  r_underflow;
    fwft_state_e           r_state;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_ram_rd;
    logic                  w_out_valid;
    logic                  w_empty_next;
    logic [CW-1:0]         w_count_next;
    logic [CW-1:0]         w_mem_count;
    logic [DATA_WIDTH-1:0] w_ram_dout;
    fwft_state_e           w_next_state;

    // Reset blocks acceptance so the RAM is never written during reset.
    assign w_wr_acc = wr_en & ~r_full & ~rst;
    assign w_rd_acc = rd_en & ~r_empty & ~rst;

    // In FWFT mode the output stage holds one of the counted words, so the
    // RAM itself holds count minus that word.
    assign w_out_valid = (r_state == FWFT_VALID);
    assign w_mem_count = r_count - (w_out_valid ? CNT_ONE_C : CNT_ZERO_C);

    // Next occupancy: +1 write, -1 read, unchanged for both or neither.
    always_comb begin
        w_count_next = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_next = r_count + CNT_ONE_C;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_next = r_count - CNT_ONE_C;
        end else begin
            w_count_next = r_count;
        end
    end

    // Prefetch control and RAM read strobe; standard mode reads on demand.
    always_comb begin
        w_next_state = r_state;
        w_ram_rd     = 1'b0;
        if (FWFT == FIFO_MODE_FWFT) begin
            case (r_state)
                FWFT_EMPTY: begin
                    if (w_mem_count != CNT_ZERO_C) begin
                        w_next_state = FWFT_PRIMING;
                    end else begin
                        w_next_state = FWFT_EMPTY;
                    end
                end
                FWFT_PRIMING: begin
                    // RAM read of the head word completes on this edge.
                    w_ram_rd     = 1'b1;
                    w_next_state = FWFT_VALID;
                end
                FWFT_VALID: begin
                    if (w_rd_acc) begin
                        if (w_mem_count != CNT_ZERO_C) begin
                            // Refill from RAM on the consuming edge: no bubble.
                            w_ram_rd     = 1'b1;
                            w_next_state = FWFT_VALID;
                        end else begin
                            w_next_state = FWFT_EMPTY;
                        end
                    end else begin
                        w_next_state = FWFT_VALID;
                    end
                end
                default: begin
                    w_next_state = FWFT_EMPTY;
                end
            endcase
        end else begin
            w_ram_rd     = w_rd_acc;
            w_next_state = FWFT_EMPTY;
        end
    end

    // Empty flag source differs by mode: count in standard, stage in FWFT.
    always_comb begin
        w_empty_next = 1'b1;
        if (FWFT == FIFO_MODE_FWFT) begin
            w_empty_next = (w_next_state != FWFT_VALID);
        end else begin
            w_empty_next = (w_count_next == CNT_ZERO_C);
        end
    end

    // Pointers, count, flags and prefetch state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= CNT_ZERO_C;
            r_full        <= 1'b0;
            r_almostfull  <= 1'b0;
            r_almostempty <= 1'b1;
            r_empty       <= 1'b1;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_state       <= FWFT_EMPTY;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE_C;
            end
            if (w_ram_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE_C;
            end
            r_count       <= w_count_next;
            r_full        <= (w_count_next == DEPTH_C);
            r_almostfull  <= (w_count_next >= AF_C);
            r_almostempty <= (w_count_next <= AE_C);
            r_empty       <= w_empty_next;
            r_overflow    <= wr_en & r_full;
            r_underflow   <= rd_en & r_empty;
            r_state       <= w_next_state;
        end
    end

    // Storage; its read register doubles as dout in both modes.
    sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_acc),
        .wr_addr (r_wr_ptr),
        .wr_data (din),
        .rd_en   (w_ram_rd),
        .rd_addr (r_rd_ptr),
        .rd_data (w_ram_dout)
    );

    assign dout        = w_ram_dout;
    assign full        = r_full;
    assign almostfull  = r_almostfull;
    assign overflow    = r_overflow;
    assign empty       = r_empty;
    assign almostempty = r_almostempty;
    assign underflow   = r_underflow;
    assign count       = r_count;

endmodule : sync_fifo_param

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    localparam int DW = 64;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int AF = 12;
    localparam int AE = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0] f_dout, s_dout;
    logic [AW:0]   f_count, s_count;
    logic f_full, f_af, f_ov, f_empty, f_ae, f_un;
    logic s_full, s_af, s_ov, s_empty, s_ae, s_un;

    int n_total = 0;
    int n_pass  = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1),
                      .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)) u_dut_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(f_full),
        .almostfull(f_af), .overflow(f_ov), .rd_en(rd_en), .dout(f_dout),
        .empty(f_empty), .almostempty(f_ae), .underflow(f_un), .count(f_count));

    sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0),
                      .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)) u_dut_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(s_full),
        .almostfull(s_af), .overflow(s_ov), .rd_en(rd_en), .dout(s_dout),
        .empty(s_empty), .almostempty(s_ae), .underflow(s_un), .count(s_count));

    // ---------------- behavioural model ----------------
    // Standard mode: a plain queue; dout takes the head on an accepted read.
    logic [DW-1:0] q_s[$];
    logic [DW-1:0] ms_dout = '0;
    logic          ms_ov = 1'b0, ms_un = 1'b0;
    // FWFT mode: queue of words still in memory plus a one-word output stage.
    // A word becomes visible two edges after the stage could first take it.
    logic [DW-1:0] q_f[$];
    logic [DW-1:0] mf_dout = '0;
    logic          mf_valid = 1'b0, mf_wait = 1'b0;
    logic          mf_ov = 1'b0, mf_un = 1'b0;

    always @(posedge clk) begin
        int cs, cf;
        bit rd_ok, wr_ok;
        if (rst) begin
            q_s.delete(); ms_dout = '0; ms_ov = 1'b0; ms_un = 1'b0;
            q_f.delete(); mf_dout = '0; mf_valid = 1'b0; mf_wait = 1'b0;
            mf_ov = 1'b0; mf_un = 1'b0;
        end else begin
            cs = q_s.size();
            rd_ok = rd_en && (cs != 0);
            wr_ok = wr_en && (cs != DEPTH);
            ms_ov = wr_en && (cs == DEPTH);
            ms_un = rd_en && (cs == 0);
            if (rd_ok) ms_dout = q_s.pop_front();
            if (wr_ok) q_s.push_back(din);

            cf = q_f.size() + int'(mf_valid);
            rd_ok = rd_en && mf_valid;
            wr_ok = wr_en && (cf != DEPTH);
            mf_ov = wr_en && (cf == DEPTH);
            mf_un = rd_en && !mf_valid;
            if (mf_valid) begin
                if (rd_ok) begin
                    if (q_f.size() != 0) mf_dout = q_f.pop_front();
                    else mf_valid = 1'b0;
                end
            end else if (mf_wait) begin
                mf_dout = q_f.pop_front();
                mf_valid = 1'b1;
                mf_wait = 1'b0;
            end else if (q_f.size() != 0) begin
                mf_wait = 1'b1;
            end
            if (wr_ok) q_f.push_back(din);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int cs, cf;
        logic [DW+10:0] exp_v, act_v;
        if (chk_en) begin
            cs = q_s.size();
            exp_v = {ms_dout, 5'(cs), cs == 0, cs == DEPTH, cs >= AF, cs <= AE, ms_ov, ms_un};
            act_v = {s_dout, s_count, s_empty, s_full, s_af, s_ae, s_ov, s_un};
            n_total++;
            if (act_v === exp_v) n_pass++;
            else $display("FAIL std_cycle t=%0t: dut={dout,count,e,f,af,ae,ov,un}=%h model=%h", $time, act_v, exp_v);

            cf = q_f.size() + int'(mf_valid);
            exp_v = {mf_dout, 5'(cf), !mf_valid, cf == DEPTH, cf >= AF, cf <= AE, mf_ov, mf_un};
            act_v = {f_dout, f_count, f_empty, f_full, f_af, f_ae, f_ov, f_un};
            n_total++;
            if (act_v === exp_v) n_pass++;
            else $display("FAIL fwft_cycle t=%0t: dut={dout,count,e,f,af,ae,ov,un}=%h model=%h", $time, act_v, exp_v);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        wr_en = w; rd_en = r; din = d;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_f_empty"}, 64'(f_empty), 64'd1);
        chk({tag, "_s_empty"}, 64'(s_empty), 64'd1);
        chk({tag, "_f_count"}, 64'(f_count), 64'd0);
        chk({tag, "_s_count"}, 64'(s_count), 64'd0);
        chk({tag, "_f_dout"},  f_dout, 64'd0);
        chk({tag, "_s_dout"},  s_dout, 64'd0);
        chk({tag, "_f_ae"},    64'(f_ae), 64'd1);
        chk({tag, "_f_full"},  64'(f_full), 64'd0);
        chk({tag, "_s_af"},    64'(s_af), 64'd0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b0, 64'd0);
        chk_en = 1'b1;
        chk_reset_values("reset");
        rst = 1'b0;

        // Fill with 0..15
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 64'(i));
        chk("fill_f_count", 64'(f_count), 64'd16);
        chk("fill_f_full", 64'(f_full), 64'd1);
        chk("fill_s_count", 64'(s_count), 64'd16);
        chk("fill_s_full", 64'(s_full), 64'd1);
        chk("fill_f_head", f_dout, 64'd0);
        step(1'b1, 1'b0, 64'd99);
        chk("ovf_f_pulse", 64'(f_ov), 64'd1);
        chk("ovf_s_pulse", 64'(s_ov), 64'd1);
        chk("ovf_f_count", 64'(f_count), 64'd16);
        step(1'b0, 1'b0, 64'd0);
        chk("ovf_f_pulse_end", 64'(f_ov), 64'd0);

        // Drain: 16 back-to-back reads, 15 stays last (99 was dropped)
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_f_dout", f_dout, 64'(i));
            step(1'b0, 1'b1, 64'd0);
            chk("drain_s_dout", s_dout, 64'(i));
        end
        chk("drain_f_empty", 64'(f_empty), 64'd1);
        chk("drain_s_empty", 64'(s_empty), 64'd1);
        step(1'b0, 1'b1, 64'd0);
        chk("udf_f_pulse", 64'(f_un), 64'd1);
        chk("udf_s_pulse", 64'(s_un), 64'd1);
        chk("udf_f_count", 64'(f_count), 64'd0);

        // Latency of a single word into an empty FIFO
        step(1'b1, 1'b0, 64'hA5);
        chk("lat_s_empty_T", 64'(s_empty), 64'd0);
        chk("lat_f_empty_T", 64'(f_empty), 64'd1);
        step(1'b0, 1'b0, 64'd0);
        chk("lat_f_empty_T1", 64'(f_empty), 64'd1);
        step(1'b0, 1'b0, 64'd0);
        chk("lat_f_empty_T2", 64'(f_empty), 64'd0);
        chk("lat_f_dout_T2", f_dout, 64'hA5);
        step(1'b0, 1'b1, 64'd0);
        chk("lat_s_dout_rd", s_dout, 64'hA5);
        chk("lat_f_empty_rd", 64'(f_empty), 64'd1);

        // Concurrent traffic at count 8
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 64'(100 + i));
        step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 64'(200 + i));
        chk("conc_f_count", 64'(f_count), 64'd8);
        chk("conc_s_count", 64'(s_count), 64'd8);
        chk("conc_f_head", f_dout, 64'd292);
        chk("conc_s_last", s_dout, 64'd291);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 64'd0);
        chk("conc_f_drained", 64'(f_count), 64'd0);

        // Thresholds stepping 0..16..0
        rst = 1'b1;
        step(1'b0, 1'b0, 64'd0);
        rst = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, 64'(300 + i));
            chk("thr_up_f_af", 64'(f_af), 64'(i >= 12));
            chk("thr_up_s_ae", 64'(s_ae), 64'(i <= 3));
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            step(1'b0, 1'b1, 64'd0);
            chk("thr_dn_s_af", 64'(s_af), 64'(i >= 12));
            chk("thr_dn_f_ae", 64'(f_ae), 64'(i <= 3));
        end

        // Reset mid-operation
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 64'(400 + i));
        step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b0, 64'd0);
        rst = 1'b1;
        step(1'b1, 1'b1, 64'd999);
        rst = 1'b0;
        chk_reset_values("midrst");
        step(1'b1, 1'b0, 64'd1);
        step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b0, 64'd0);
        chk("midrst_f_dout", f_dout, 64'd1);
        chk("midrst_f_empty", 64'(f_empty), 64'd0);
        step(1'b0, 1'b1, 64'd0);
        chk("midrst_s_dout", s_dout, 64'd1);
        chk("midrst_s_count", 64'(s_count), 64'd0);
        step(1'b0, 1'b0, 64'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_sync_fifo_param
